apb_subsystem: RTL and testbench



---
 rtl/apb_subsystem.sv | 121 ++++++++++++
 tb/tb_apb_subsystem.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/apb_subsystem.sv
// APB3 single-master subsystem: request/ready CPU port, 4-slot decoder at 0x1000_0000,
// 16-word RAM (slot 0), two 4-register blocks (slots 1-2) and a default responder (slot 3).

module apb_regblk (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [1:0]  idx,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready
);
    logic [3:0][31:0] regs;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            regs <= '0;
        else if (psel && penable && pwrite)
            regs[idx] <= pwdata;
    end

    assign prdata = regs[idx];
    assign pready = psel & penable;
endmodule

module apb_subsystem (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    output logic [31:0] PWDATA
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state;
    logic             bus_act;
    logic             in_win;
    logic [1:0]       slot;
    logic [3:0]       pready;
    logic [3:0][31:0] prdata;
    logic             sel_pready;
    logic [31:0]      ram [16];
    logic             unused_addr_bits;

    assign in_win = (PADDR[31:14] == 18'h04000);
    assign slot   = PADDR[13:12];
    assign PSEL   = (bus_act && in_win) ? (4'b0001 << slot) : 4'b0000;

    // Out-of-window transfers have no slave; the master completes them itself.
    assign sel_pready = in_win ? pready[slot] : PENABLE;
    assign ready      = (state == ACCESS) && sel_pready;
    assign rdata      = (ready && !PWRITE && in_win) ? prdata[slot] : 32'h0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            bus_act <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
        end else begin
            case (state)
                IDLE: if (transfer) begin
                    state   <= SETUP;
                    bus_act <= 1'b1;
                    PADDR   <= addr;
                    PWRITE  <= write;
                    PWDATA  <= wdata;
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: if (sel_pready) begin
                    state   <= IDLE;
                    bus_act <= 1'b0;
                    PENABLE <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot 0: word RAM, no reset, upper offset bits alias.
    always_ff @(posedge PCLK) begin
        if (PSEL[0] && PENABLE && PWRITE)
            ram[PADDR[5:2]] <= PWDATA;
    end
    assign prdata[0] = ram[PADDR[5:2]];
    assign pready[0] = PSEL[0] & PENABLE;

    for (genvar g = 1; g < 3; g++) begin : g_blk
        apb_regblk u_blk (
            .PCLK    (PCLK),
            .PRESET  (PRESET),
            .psel    (PSEL[g]),
            .penable (PENABLE),
            .pwrite  (PWRITE),
            .idx     (PADDR[3:2]),
            .pwdata  (PWDATA),
            .prdata  (prdata[g]),
            .pready  (pready[g])
        );
    end

    assign prdata[3] = 32'h0;
    assign pready[3] = PSEL[3] & PENABLE;

    assign unused_addr_bits = ^{PADDR[11:6], PADDR[1:0]};
endmodule

// File: tb/tb_apb_subsystem.sv
// Directed + randomized bench for apb_subsystem against an address-map level reference model.

module tb_apb_subsystem;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] PADDR;
    logic        PWRITE, PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PWDATA;

    int vectors = 0;
    int errors  = 0;
    int rdy_cnt = 0;

    logic [31:0] m_ram  [16];
    logic [31:0] m_regs [2][4];

    apb_subsystem dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PWDATA(PWDATA)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) if (ready) rdy_cnt <= rdy_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    function automatic bit m_inwin(input logic [31:0] a);
        return a[31:14] == (32'h1000_0000 >> 14);
    endfunction

    function automatic logic [3:0] m_psel(input logic [31:0] a);
        return m_inwin(a) ? 4'(1 << a[13:12]) : 4'b0000;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_inwin(a)) return 32'h0;
        case (a[13:12])
            2'd0:    return m_ram[a[5:2]];
            2'd1:    return m_regs[0][a[3:2]];
            2'd2:    return m_regs[1][a[3:2]];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        if (m_inwin(a)) begin
            if (a[13:12] == 2'd0)      m_ram[a[5:2]] = d;
            else if (a[13:12] != 2'd3) m_regs[a[13:12] - 2'd1][a[3:2]] = d;
        end
    endtask

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 4; r++) m_regs[b][r] = 32'h0;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  e_psel;
        logic [31:0] e_rd;
        e_psel   = m_psel(a);
        e_rd     = w ? 32'h0 : m_read(a);
        transfer = 1'b1; write = w; addr = a; wdata = d;
        step();
        transfer = 1'b0; addr = $urandom; wdata = $urandom; write = ~w;
        chk("setup_psel", 32'(PSEL), 32'(e_psel));
        chk("setup_penable", 32'(PENABLE), 32'h0);
        chk("setup_ready", 32'(ready), 32'h0);
        step();
        chk("access_ready", 32'(ready), 32'h1);
        chk("access_psel", 32'(PSEL), 32'(e_psel));
        chk("access_penable", 32'(PENABLE), 32'h1);
        chk("access_paddr", PADDR, a);
        chk("access_pwrite", 32'(PWRITE), 32'(w));
        if (w) chk("access_pwdata", PWDATA, d);
        else   chk("access_rdata", rdata, e_rd);
        step();
        chk("idle_ready", 32'(ready), 32'h0);
        chk("idle_paddr_hold", PADDR, a);
        if (w) m_write(a, d);
    endtask

    initial begin
        int c0;
        logic [31:0] a;
        transfer = 0; write = 0; addr = 0; wdata = 0;
        PRESET = 1'b1;
        m_reset();
        repeat (2) step();
        chk("rst_psel", 32'(PSEL), 32'h0);
        chk("rst_penable", 32'(PENABLE), 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwrite", 32'(PWRITE), 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        PRESET = 1'b0;
        step();

        xfer(1, 32'h1000_0000, 32'd1);
        xfer(1, 32'h1000_0004, 32'd2);
        xfer(1, 32'h1000_0008, 32'd3);
        xfer(0, 32'h1000_0000, 0);
        xfer(0, 32'h1000_0004, 0);
        xfer(0, 32'h1000_0008, 0);
        xfer(1, 32'h1000_1000, 32'd20);
        xfer(1, 32'h1000_2000, 32'd12);
        xfer(0, 32'h1000_1000, 0);
        xfer(0, 32'h1000_2000, 0);
        xfer(0, 32'h1000_1004, 0);
        xfer(1, 32'h1000_0040, 32'hA5A5_A5A5);
        xfer(0, 32'h1000_0000, 0);
        xfer(0, 32'h1000_3000, 0);
        xfer(1, 32'h2000_0000, 32'hDEAD_BEEF);
        xfer(0, 32'h2000_0000, 0);

        // Stray transfer pulses in SETUP and ACCESS must not start new transfers.
        c0 = rdy_cnt;
        transfer = 1; write = 0; addr = 32'h1000_1000;
        step();
        step();
        step();
        transfer = 0;
        repeat (4) step();
        chk("one_ready_per_xfer", 32'(rdy_cnt - c0), 32'd1);

        // Reset during ACCESS of a register write.
        c0 = rdy_cnt;
        transfer = 1; write = 1; addr = 32'h1000_1008; wdata = 32'h1234_5678;
        step();
        transfer = 0;
        step();
        PRESET = 1'b1;
        #1;
        chk("abort_ready", 32'(ready), 32'h0);
        chk("abort_psel", 32'(PSEL), 32'h0);
        step();
        PRESET = 1'b0;
        m_reset();
        step();
        chk("abort_no_ready", 32'(rdy_cnt - c0), 32'd0);
        xfer(0, 32'h1000_1008, 0);

        for (int i = 0; i < 16; i++) xfer(1, 32'h1000_0000 | 32'(i * 4), $urandom);
        for (int i = 0; i < 60; i++) begin
            int s;
            s = $urandom_range(0, 4);
            if (s == 4) a = 32'h2000_0000 | ($urandom & 32'h0000_3FFC);
            else        a = 32'h1000_0000 | 32'(s << 12) | ($urandom & 32'h0000_0FFF);
            xfer(1'($urandom), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
